// File: rtl/transformation_scheduler_pkg.sv
// Shared types for the GCN transformation block:
// scheduler state encoding and default tile sizes.
package gcn_pkg;

  localparam int FEATURE_ROWS_DEF   = 6;
  localparam int WEIGHT_COLS_DEF    = 3;
  localparam int DOT_PROD_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_ROW = 3'd1,
    FETCH_COL = 3'd2,
    MULT      = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5
  } sched_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transformation_scheduler_tile_index_counter.sv
// Nested row/column index counter for the
// feature x weight tile walk.
module tile_index_counter
  import gcn_pkg::*;
#(
  parameter int ROWS = FEATURE_ROWS_DEF,
  parameter int COLS = WEIGHT_COLS_DEF,
  parameter int RW   = addr_w(ROWS),
  parameter int CW   = addr_w(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_col,
  output logic          last_elem
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic last_row;

  assign last_row  = (row == ROW_LAST);
  assign last_col  = (col == COL_LAST);
  assign last_elem = last_row & last_col;

  // column steps first, row steps when the column wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/transformation_scheduler.sv
// Sequencer driving memories, the shared dot-product
// unit and the output feature-map write port.
module transformation_scheduler
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS   = FEATURE_ROWS_DEF,
  parameter int WEIGHT_COLS    = WEIGHT_COLS_DEF,
  parameter int DOT_PROD_WIDTH = DOT_PROD_WIDTH_DEF,
  parameter int ROW_ADDR_WIDTH = addr_w(FEATURE_ROWS),
  parameter int COL_ADDR_WIDTH = addr_w(WEIGHT_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic                      read_feature_enable,
  output logic [ROW_ADDR_WIDTH-1:0] read_feature_address,
  output logic                      read_weight_enable,
  output logic [COL_ADDR_WIDTH-1:0] read_weight_address,
  output logic                      mult_enable,
  input  logic [DOT_PROD_WIDTH-1:0] dot_product,
  output logic                      write_enable,
  output logic [ROW_ADDR_WIDTH-1:0] write_row_address,
  output logic [COL_ADDR_WIDTH-1:0] write_col_address,
  output logic [DOT_PROD_WIDTH-1:0] write_data,
  output logic                      busy,
  output logic                      done
);

  sched_state_t              state;
  logic [ROW_ADDR_WIDTH-1:0] row;
  logic [COL_ADDR_WIDTH-1:0] col;
  logic                      last_col;
  logic                      last_elem;
  logic                      clear;
  logic                      advance;

  assign clear   = (state == IDLE) | (state == DONE) | abort;
  assign advance = (state == WRITE) & ~last_elem;

  tile_index_counter #(
    .ROWS (FEATURE_ROWS),
    .COLS (WEIGHT_COLS),
    .RW   (ROW_ADDR_WIDTH),
    .CW   (COL_ADDR_WIDTH)
  ) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .advance   (advance),
    .row       (row),
    .col       (col),
    .last_col  (last_col),
    .last_elem (last_elem)
  );

  // abort wins over every transition once a pass is running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:      if (start && !abort) state <= FETCH_ROW;
        FETCH_ROW: state <= FETCH_COL;
        FETCH_COL: state <= MULT;
        MULT:      state <= WRITE;
        WRITE: begin
          if (!last_col)       state <= FETCH_COL;
          else if (!last_elem) state <= FETCH_ROW;
          else                 state <= DONE;
        end
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign read_feature_enable  = (state == FETCH_ROW);
  assign read_weight_enable   = (state == FETCH_COL);
  assign mult_enable          = (state == MULT);
  assign write_enable         = (state == WRITE);
  assign done                 = (state == DONE);
  assign busy                 = (state != IDLE);

  assign read_feature_address = row;
  assign write_row_address    = row;
  assign read_weight_address  = col;
  assign write_col_address    = col;
  assign write_data = write_enable ? dot_product : '0;

endmodule

// File: tb/tb_transformation_scheduler.sv
// Scoreboard bench for transformation_scheduler with
// behavioural memories and dot-product unit.
module tb_transformation_scheduler;

  localparam int R = 6;
  localparam int C = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rfe, rwe, me, we, busy, done;
  logic [2:0]  rfa, wra;
  logic [1:0]  rwa, wca;
  logic [15:0] wd;
  logic [15:0] dot_product = '0;

  transformation_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .read_feature_enable  (rfe),
    .read_feature_address (rfa),
    .read_weight_enable   (rwe),
    .read_weight_address  (rwa),
    .mult_enable          (me),
    .dot_product          (dot_product),
    .write_enable         (we),
    .write_row_address    (wra),
    .write_col_address    (wca),
    .write_data           (wd),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tab [R][C];
  int frow_q = 0;
  int wcol_q = 0;

  always @(posedge clk) begin
    if (rfe) frow_q <= int'(rfa);
    if (rwe) wcol_q <= int'(rwa);
    if (me)  dot_product <= tab[frow_q][wcol_q];
  end

  typedef struct {
    int          r;
    int          c;
    logic [15:0] d;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  bit  busy_exp[int];

  int compared = 0;
  int mismatched = 0;
  int n_rfe = 0;
  int n_rwe = 0;
  bit prev_rwe = 0;
  bit prev_me = 0;
  bit be;
  wr_t w;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               n, cyc, act, exp);
    end
  endtask

  task automatic fail(input string n);
    compared++;
    mismatched++;
    $display("FAIL %s cyc=%0d", n, cyc);
  endtask

  // monitor: compares DUT outputs with the scoreboard
  always @(negedge clk) begin
    be = busy_exp.exists(cyc) ? busy_exp[cyc] : 1'b0;
    chk("busy", {31'd0, busy}, {31'd0, be});
    if (!be) begin
      chk("idle_outs",
          {1'b0, rfe, rwe, me, we, done, rfa, rwa, wra, wca, wd}, 0);
    end else begin
      if (!we) chk("wdata_zero", {16'd0, wd}, 0);
      chk("addr_bound", {31'd0, (rfa < 3'd6) && (rwa < 2'd3)}, 1);
    end
    if (me) chk("mult_after_rw", {31'd0, prev_rwe}, 1);
    if (we) chk("write_after_mult", {31'd0, prev_me}, 1);
    prev_rwe = rwe;
    prev_me  = me;
    if (rfe) n_rfe++;
    if (rwe) n_rwe++;
    if (we) begin
      if (wq.size() == 0) begin
        fail("unexpected_write");
      end else begin
        w = wq.pop_front();
        chk("write_row", {29'd0, wra}, w.r);
        chk("write_col", {30'd0, wca}, w.c);
        chk("write_data", {16'd0, wd}, {16'd0, w.d});
      end
    end
    if (done) begin
      if (dq.size() == 0) fail("unexpected_done");
      else chk("done_cycle", cyc, dq.pop_front());
    end
    if (dq.size() > 0 && cyc > dq[0]) begin
      fail("missing_done");
      void'(dq.pop_front());
    end
  end

  // reference: element (r,c) is written k=4+10r+3c cycles
  // after start is sampled; the pass ends at k=61 unless
  // cut short at end_k
  task automatic model(input int t, input int ab, input int rs);
    int end_k;
    end_k = (ab != 0) ? ab : (rs != 0) ? rs - 1 : 1 + R * (1 + 3 * C);
    for (int k = 1; k <= end_k; k++) busy_exp[t + k] = 1'b1;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (4 + 10 * r + 3 * c <= end_k)
          wq.push_back('{r, c, tab[r][c]});
    if (ab == 0 && rs == 0) dq.push_back(t + 1 + R * (1 + 3 * C));
  endtask

  task automatic randomize_tab();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        tab[r][c] = 16'($urandom);
  endtask

  task automatic run_pass(input int ab, input int rs, input bit hold,
                          input int x1, input int x2, input int rst_k);
    int t;
    int len;
    @(posedge clk); #1;
    t = cyc;
    start = 1'b1;
    model(t, ab, rs);
    if (hold) model(t + 62, 0, 0);
    if (rst_k != 0) model(t + rst_k, 0, 0);
    len = hold ? 126 : (rst_k != 0) ? rst_k + 64 : 65;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      start = (hold && k <= 62) || (x1 != 0 && k == x1) ||
              (x2 != 0 && k == x2) || (rst_k != 0 && k == rst_k);
      abort = (ab != 0 && k == ab);
      if (rs != 0 && k == rs) begin
        #1 reset = 1'b0;
      end
      if (rs != 0 && k == rs + 2) reset = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int f0;
    int w0;
    int ab;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);

    randomize_tab();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        tab[r][c] = 16'(r * 16 + c);
    f0 = n_rfe;
    w0 = n_rwe;
    run_pass(0, 0, 1'b0, 0, 0, 0);
    chk("rfe_count", n_rfe - f0, R);
    chk("rwe_count", n_rwe - w0, R * C);

    randomize_tab();
    run_pass(0, 0, 1'b0, 5, 30, 0);

    randomize_tab();
    run_pass(20, 0, 1'b0, 0, 0, 25);

    randomize_tab();
    run_pass(0, 33, 1'b0, 0, 0, 0);
    run_pass(0, 0, 1'b0, 0, 0, 0);

    randomize_tab();
    run_pass(0, 0, 1'b1, 0, 0, 0);

    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      randomize_tab();
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
      run_pass(ab, 0, 1'b0, 0, 0, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("writes_left", wq.size(), 0);
    chk("dones_left", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/transformation_scheduler.md
Name: transformation_scheduler

Overview:
- FSM controller that sequences the shared dot-product unit across a full feature × weight product for the GCN transformation block.
- For each feature row and each weight column it:
  - issues memory read strobes and addresses,
  - pulses the multiplier enable,
  - writes the registered dot product into the output feature-map memory.
- Sits between the top-level start/done handshake and the feature memory, weight memory, dot-product unit and output memory.

Parameters:
- FEATURE_ROWS, 6: number of feature-matrix rows (nodes).
- WEIGHT_COLS, 3: number of weight-matrix columns (output features).
- DOT_PROD_WIDTH, 16: width of the dot-product result and of the write data.
- ROW_ADDR_WIDTH, $clog2(FEATURE_ROWS) (min 1): row address width.
- COL_ADDR_WIDTH, $clog2(WEIGHT_COLS) (min 1): column address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a full pass; sampled in IDLE only.
- abort  in  1  synchronous abandon of the pass; highest priority after reset.
- read_feature_enable  out  1  feature memory read strobe.
- read_feature_address  out  ROW_ADDR_WIDTH  feature row to read.
- read_weight_enable  out  1  weight memory read strobe.
- read_weight_address  out  COL_ADDR_WIDTH  weight column to read.
- mult_enable  out  1  enable of the dot-product unit.
- dot_product  in  DOT_PROD_WIDTH  registered result from the dot-product unit.
- write_enable  out  1  output memory write strobe.
- write_row_address  out  ROW_ADDR_WIDTH  output row.
- write_col_address  out  COL_ADDR_WIDTH  output column.
- write_data  out  DOT_PROD_WIDTH  output data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, row=0, col=0.
  - All outputs 0.
  - A reset mid-pass discards the pass; no done pulse.
- Outputs are decoded from registered state and counters (Moore). Strobes are high only in their own state; otherwise 0.
- Addresses:
  - read_feature_address = write_row_address = row.
  - read_weight_address = write_col_address = col.
- write_data = dot_product while write_enable=1, else 0.
- Memories have 1-cycle registered read latency.
- The dot-product unit registers its result at the end of the mult_enable cycle.
- States:
  - IDLE: start=1 → row=0, col=0, go to FETCH_ROW. Otherwise stay.
  - FETCH_ROW: read_feature_enable=1 for 1 cycle → FETCH_COL.
  - FETCH_COL: read_weight_enable=1 for 1 cycle → MULT.
  - MULT: mult_enable=1 for 1 cycle → WRITE.
  - WRITE: write_enable=1 for 1 cycle; exit depends on counters:
    - col<WEIGHT_COLS-1 → col++, go to FETCH_COL (feature row is not re-read).
    - Else, row<FEATURE_ROWS-1 → col=0, row++, go to FETCH_ROW.
    - Else → DONE.
  - DONE: done=1 for 1 cycle → IDLE. Counters are cleared.
- Latency: with start sampled in cycle T, done is high in cycle T+1+FEATURE_ROWS*(1+3*WEIGHT_COLS).
  - Defaults: T+61.
  - Exactly FEATURE_ROWS*WEIGHT_COLS write_enable pulses per pass.
- start outside IDLE is ignored. start held high re-triggers a pass from IDLE after DONE (back-to-back passes, one IDLE cycle between).
- abort=1 in any non-IDLE state → IDLE next cycle; counters cleared; no done pulse.
  - If the same cycle is WRITE, that write still occurs.
  - abort in IDLE has no effect and blocks start in that cycle.
- Counter wrap:
  - col wraps only at WEIGHT_COLS-1, row only at FEATURE_ROWS-1.
  - No address ever exceeds its bound.
  - With FEATURE_ROWS=1 or WEIGHT_COLS=1 the same rules apply; no illegal state.
- Illegal state encodings recover to IDLE via the default branch.

Decomposition:
- Shared package gcn_pkg:
  - typedef enum sched_state_t {IDLE, FETCH_ROW, FETCH_COL, MULT, WRITE, DONE};
  - localparams for the default row/column counts.
- One sub-module: tile_index_counter, the row/col nested counter.
  - Inputs: clear, advance.
  - Outputs: row, col, last_col, last_elem.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release → all outputs 0, busy=0 with start=0 for 10 cycles.
- Full pass (defaults): start pulse at T, dot_product driven as row*16+col → 18 writes in (row,col) order (0,0),(0,1),(0,2),(1,0)…(5,2), each write_data correct, done high only at T+61, busy low at T+62.
- Strobe ordering: per element, read_weight_enable, mult_enable and write_enable each fire on consecutive cycles; read_feature_enable fires 6 times per pass, read_weight_enable 18 times.
- start during busy: extra start pulses at T+5 and T+30 → no restart; done still at T+61 only.
- abort: abort=1 at T+20 → IDLE at T+21, counters 0, no done; a new start at T+25 gives done at T+86.
- Async reset mid-pass: reset=0 at T+33 (between edges) → outputs 0 immediately, no done; restart produces a full correct 18-write pass.
